// File: rtl/muldiv_ctrl_pkg.sv
// Shared types and constants for the EX-stage HI/LO multiply/divide sequencer.
// Imported by the sequencer top and its restoring-divide step.
package muldiv_ctrl_pkg;

  localparam int DIV_BITS = 32;
  localparam logic [1:0] HILO_W_BOTH = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  function automatic logic [31:0] mag(
    input logic [31:0] v,
    input logic        sgn
  );
    return (sgn && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// One restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference when it is non-negative.
module muldiv_ctrl_div_iter
  import muldiv_ctrl_pkg::*;
#(
  parameter int W = DIV_BITS
) (
  input  logic [W:0]   rem_in,
  input  logic         dvd_msb,
  input  logic [W-1:0] dvs,
  output logic [W:0]   rem_out,
  output logic         q_bit
);

  logic [W+1:0] sh;
  logic [W+1:0] dvs_x;

  always_comb begin
    sh      = {rem_in, dvd_msb};
    dvs_x   = {2'b00, dvs};
    q_bit   = (sh >= dvs_x);
    rem_out = q_bit ? (W+1)'(sh - dvs_x) : sh[W:0];
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle HI/LO multiply/divide sequencer for EX: stalls while busy,
// then writes {HI,LO} when the instruction advances to MEM.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_BITS   = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_valid,
  input  logic        ex_mult,
  input  logic        ex_div,
  input  logic        ex_mdsign,
  input  logic [31:0] ex_rs_val,
  input  logic [31:0] ex_rt_val,
  input  logic        ex_adv,
  input  logic        flush,
  output logic        md_stall,
  output logic        md_busy,
  output logic [1:0]  hilo_wen,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  md_state_e   state, state_nxt;
  logic [4:0]  cnt;
  logic [31:0] op_a, op_b;
  logic [31:0] res_hi, res_lo;
  logic [32:0] rem, rem_nxt;
  logic        qneg, rneg, q_bit;
  logic        start, mul_last, div_last;
  logic [63:0] prod;
  logic [31:0] quo_fin;

  // resetn gate keeps md_stall low while reset is held
  assign start = resetn && (state == MD_IDLE) && ex_valid
               && (ex_mult || ex_div) && !flush;

  assign mul_last = (cnt == 5'(MUL_CYCLES - 1));
  assign div_last = (cnt == 5'(DIV_BITS - 1));
  assign prod     = 64'(op_a) * 64'(op_b);
  assign quo_fin  = {op_a[30:0], q_bit};

  muldiv_ctrl_div_iter #(
    .W(DIV_BITS)
  ) u_div_iter (
    .rem_in (rem),
    .dvd_msb(op_a[31]),
    .dvs    (op_b),
    .rem_out(rem_nxt),
    .q_bit  (q_bit)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= MD_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      MD_IDLE: begin
        if (start) state_nxt = ex_div ? MD_DIV : MD_MUL;
      end
      MD_MUL:  if (mul_last) state_nxt = MD_DONE;
      MD_DIV:  if (div_last) state_nxt = MD_DONE;
      MD_DONE: if (ex_adv)   state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
    if (flush) state_nxt = MD_IDLE;
  end

  always_comb begin
    md_stall = (start || state == MD_MUL || state == MD_DIV) && !flush;
    md_busy  = (state != MD_IDLE);
    hilo_wen = (state == MD_DONE && ex_adv && !flush) ? HILO_W_BOTH : 2'b00;
    hi_out   = res_hi;
    lo_out   = res_lo;
  end

  // op_a doubles as the dividend shift register collecting quotient bits
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      rem    <= '0;
      qneg   <= 1'b0;
      rneg   <= 1'b0;
      res_hi <= '0;
      res_lo <= '0;
    end else if (!flush) begin
      unique case (state)
        MD_IDLE: begin
          if (start) begin
            op_a <= mag(ex_rs_val, ex_mdsign);
            op_b <= mag(ex_rt_val, ex_mdsign);
            rem  <= '0;
            cnt  <= '0;
            qneg <= ex_mdsign && (ex_rs_val[31] ^ ex_rt_val[31]);
            rneg <= ex_mdsign && ex_rs_val[31];
          end
        end
        MD_MUL: begin
          cnt <= cnt + 5'd1;
          if (mul_last) {res_hi, res_lo} <= qneg ? -prod : prod;
        end
        MD_DIV: begin
          cnt  <= cnt + 5'd1;
          op_a <= quo_fin;
          rem  <= rem_nxt;
          if (div_last) begin
            res_lo <= qneg ? -quo_fin : quo_fin;
            res_hi <= rneg ? -rem_nxt[31:0] : rem_nxt[31:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: latency, results, flush, DONE hold
// and asynchronous reset, with hand-computed expectations.
module tb_muldiv_ctrl;

  logic        clk;
  logic        resetn;
  logic        ex_valid;
  logic        ex_mult;
  logic        ex_div;
  logic        ex_mdsign;
  logic [31:0] ex_rs_val;
  logic [31:0] ex_rt_val;
  logic        ex_adv;
  logic        flush;
  logic        md_stall;
  logic        md_busy;
  logic [1:0]  hilo_wen;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int n_cmp;
  int n_bad;

  muldiv_ctrl #(
    .MUL_CYCLES(2),
    .DIV_BITS  (32)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .ex_valid (ex_valid),
    .ex_mult  (ex_mult),
    .ex_div   (ex_div),
    .ex_mdsign(ex_mdsign),
    .ex_rs_val(ex_rs_val),
    .ex_rt_val(ex_rt_val),
    .ex_adv   (ex_adv),
    .flush    (flush),
    .md_stall (md_stall),
    .md_busy  (md_busy),
    .hilo_wen (hilo_wen),
    .hi_out   (hi_out),
    .lo_out   (lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic m, input logic d, input logic s,
                       input logic [31:0] rs, input logic [31:0] rt);
    @(negedge clk);
    ex_valid  = 1'b1;
    ex_mult   = m;
    ex_div    = d;
    ex_mdsign = s;
    ex_rs_val = rs;
    ex_rt_val = rt;
    ex_adv    = 1'b0;
    #1;
  endtask

  task automatic run_op(input string tag, input logic m, input logic d,
                        input logic s, input logic [31:0] rs,
                        input logic [31:0] rt, input int exp_stall,
                        input int hold, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int n;
    issue(m, d, s, rs, rt);
    n = 0;
    while (md_stall && n < 100) begin
      n++;
      step();
    end
    chk({tag, "_stall"}, 64'(n), 64'(exp_stall));
    chk({tag, "_busy"}, 64'(md_busy), 64'd1);
    for (int i = 0; i < hold; i++) begin
      chk({tag, "_hold_wen"}, 64'(hilo_wen), 64'd0);
      chk({tag, "_hold_res"}, {hi_out, lo_out}, {exp_hi, exp_lo});
      chk({tag, "_hold_stall"}, 64'(md_stall), 64'd0);
      step();
    end
    chk({tag, "_prewen"}, 64'(hilo_wen), 64'd0);
    ex_adv = 1'b1;
    #1;
    chk({tag, "_wen"}, 64'(hilo_wen), 64'd3);
    chk({tag, "_res"}, {hi_out, lo_out}, {exp_hi, exp_lo});
    @(negedge clk);
    ex_valid = 1'b0;
    ex_mult  = 1'b0;
    ex_div   = 1'b0;
    #1;
    chk({tag, "_wen_once"}, 64'(hilo_wen), 64'd0);
    chk({tag, "_idle"}, 64'(md_busy), 64'd0);
    ex_adv = 1'b0;
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    resetn    = 1'b0;
    ex_valid  = 1'b0;
    ex_mult   = 1'b0;
    ex_div    = 1'b0;
    ex_mdsign = 1'b0;
    ex_rs_val = '0;
    ex_rt_val = '0;
    ex_adv    = 1'b0;
    flush     = 1'b0;
    #12;
    chk("rst_stall", 64'(md_stall), 64'd0);
    chk("rst_busy", 64'(md_busy), 64'd0);
    chk("rst_wen", 64'(hilo_wen), 64'd0);
    chk("rst_res", {hi_out, lo_out}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    run_op("divu_100_7", 1'b0, 1'b1, 1'b0, 32'd100, 32'd7,
           33, 0, 32'd2, 32'd14);
    run_op("div_m7_2", 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,
           33, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_ovf", 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
           33, 0, 32'h0, 32'h8000_0000);
    run_op("mult_m3_5", 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5,
           3, 0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("multu_max", 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           3, 0, 32'hFFFF_FFFE, 32'h1);
    run_op("divu_9_0", 1'b0, 1'b1, 1'b0, 32'd9, 32'd0,
           33, 0, 32'd9, 32'hFFFF_FFFF);

    issue(1'b0, 1'b1, 1'b0, 32'd1000, 32'd3);
    for (int i = 0; i < 10; i++) step();
    chk("flush_pre_stall", 64'(md_stall), 64'd1);
    flush = 1'b1;
    #1;
    chk("flush_stall", 64'(md_stall), 64'd0);
    chk("flush_wen", 64'(hilo_wen), 64'd0);
    @(negedge clk);
    flush    = 1'b0;
    ex_valid = 1'b0;
    ex_div   = 1'b0;
    #1;
    chk("flush_idle", 64'(md_busy), 64'd0);
    chk("flush_nowen", 64'(hilo_wen), 64'd0);
    run_op("divu_6_3", 1'b0, 1'b1, 1'b0, 32'd6, 32'd3,
           33, 0, 32'd0, 32'd2);

    run_op("multu_hold", 1'b1, 1'b0, 1'b0, 32'd7, 32'd6,
           3, 4, 32'd0, 32'd42);

    issue(1'b1, 1'b0, 1'b1, 32'd123, 32'd456);
    step();
    chk("rstmid_busy", 64'(md_busy), 64'd1);
    chk("rstmid_stall", 64'(md_stall), 64'd1);
    ex_valid = 1'b0;
    ex_mult  = 1'b0;
    #1;
    resetn = 1'b0;
    #1;
    chk("rstmid_stall0", 64'(md_stall), 64'd0);
    chk("rstmid_busy0", 64'(md_busy), 64'd0);
    chk("rstmid_wen0", 64'(hilo_wen), 64'd0);
    chk("rstmid_res0", {hi_out, lo_out}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    run_op("div_m9_0", 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF7, 32'd0,
           33, 0, 32'hFFFF_FFF7, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
